// File: rtl/data_mem_ctrl.sv
// Single-port data memory with a boot-table INIT sequence, byte-masked writes
// and a registered one-cycle read path.
module data_mem_ctrl #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] be,
    output logic            ready,
    output logic [DW-1:0]   rdata,
    output logic            rvalid
);

    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   cnt_nxt;

    logic            wr_en_p0;
    logic [AW-1:0]   wr_addr_p0;
    logic [DW-1:0]   wr_data_p0;
    logic [NB-1:0]   wr_be_p0;
    logic            rd_en_p0;

    logic [DW-1:0]   mem [DEPTH];

    function automatic logic [DW-1:0] boot_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        if (a == '0)
            w[15:0] = 16'h00AB;
        else if (a == AW'(1))
            w[15:0] = 16'h3C00;
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // INIT owns the single array port; in RUN a clr drops any request on that edge.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wr_en_p0   = 1'b0;
        wr_addr_p0 = addr;
        wr_data_p0 = wdata;
        wr_be_p0   = be;
        rd_en_p0   = 1'b0;
        case (state)
            INIT: begin
                wr_en_p0 = 1'b1;
                wr_be_p0 = '1;
                if (clr) begin
                    wr_addr_p0 = '0;
                    cnt_nxt    = AW'(1);
                end else begin
                    wr_addr_p0 = cnt;
                    cnt_nxt    = cnt + 1'b1;
                    if (cnt == LAST_ADDR)
                        state_nxt = RUN;
                end
                wr_data_p0 = boot_word(wr_addr_p0);
            end
            RUN: begin
                if (clr) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end else if (req) begin
                    if (we)
                        wr_en_p0 = 1'b1;
                    else
                        rd_en_p0 = 1'b1;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign ready = (state == RUN);

    // Stage p0 -> array: byte-masked write, contents survive rst until INIT rewrites them.
    always_ff @(posedge clk) begin
        if (wr_en_p0) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_p0[i])
                    mem[wr_addr_p0][8*i +: 8] <= wr_data_p0[8*i +: 8];
            end
        end
    end

    // Stage p0 -> output register: rdata holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en_p0;
            if (rd_en_p0)
                rdata <= mem[addr];
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DW, default 16: data word width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter AW, default 8: address width; memory depth DEPTH = 2^AW words.
REQ-003 clk  input  1  clock; all state changes on its rising edge except reset.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clr  input  1  synchronous re-initialise request; sampled on a clk edge.
REQ-006 req  input  1  access request, valid only while ready=1.
REQ-007 we  input  1  1=write, 0=read; qualified by req.
REQ-008 addr  input  AW  word address.
REQ-009 wdata  input  DW  write data.
REQ-010 be  input  DW/8  byte enables; bit i covers wdata[8i+7:8i].
REQ-011 ready  output  1  1=block accepts requests (RUN state).
REQ-012 rdata  output  DW  registered read data.
REQ-013 rvalid  output  1  one-cycle pulse marking rdata valid.

Function
REQ-014 The block SHALL be a two-state FSM, INIT and RUN, with a storage array of DEPTH x DW bits and an AW-bit init counter.
REQ-015 In INIT, the block SHALL write one word per cycle at address = counter, then increment the counter; boot table: word 0 = 16'h00AB, word 1 = 16'h3C00, all other words 0, zero-extended when DW>16.
REQ-016 INIT SHALL last exactly DEPTH cycles; the edge writing address DEPTH-1 SHALL move the FSM to RUN, so ready=1 on the following cycle.
REQ-017 ready SHALL be 1 exactly when the FSM is in RUN.
REQ-018 In INIT, req SHALL be ignored: no array write, no rvalid.
REQ-019 In RUN, req=1 with we=1 SHALL update only the bytes of mem[addr] whose be bit is 1, at that edge; rvalid stays 0.
REQ-020 In RUN, req=1 with we=0 SHALL load rdata with mem[addr] and set rvalid=1 at that edge: latency 1 cycle, one read per cycle, back-to-back allowed.
REQ-021 rvalid SHALL be 0 in any cycle not following an accepted read; rdata SHALL hold its last value when rvalid=0.
REQ-022 A read in the cycle after a write to the same address SHALL return the written data.
REQ-023 be=0 with we=1 SHALL be a no-op write; addr wraps naturally at DEPTH (no out-of-range case).
REQ-024 clr=1 in RUN SHALL move the FSM to INIT with counter 0 at that edge; a simultaneous req SHALL be dropped (no write, no rvalid).
REQ-025 clr=1 during INIT SHALL restart the sequence at counter 0; that edge SHALL write address 0 with its boot value.
REQ-026 Counter SHALL not be used as a read path; the array has a single port, and INIT writes take priority over all requests.

Reset
REQ-027 rst=0 SHALL immediately force FSM=INIT, counter=0, ready=0, rvalid=0, rdata=0, independent of clk.
REQ-028 The array SHALL not be asynchronously cleared; its contents SHALL be established by the INIT sequence after rst returns to 1.
REQ-029 rst asserted mid-access SHALL abort it: a pending read's rvalid SHALL not appear; a write on the same edge as reset assertion is not guaranteed.

Verification (DW=16, AW=8)
REQ-030 Release rst, clr=0 -> ready=0 for 256 cycles, ready=1 from cycle 257; req pulsed during INIT yields no rvalid.
REQ-031 After init, read addr 0, 1, 2, 7 back-to-back -> rvalid high 4 cycles, rdata 16'h00AB, 16'h3C00, 16'h0000, 16'h0000.
REQ-032 Write addr 1, wdata 16'h1234, be=2'b01, then read addr 1 -> rdata 16'h3C34; then be=2'b00 write 16'hFFFF to addr 1 -> read 16'h3C34.
REQ-033 Write 16'hBEEF to addr 255, assert clr together with a read req -> no rvalid, ready=0 for 256 cycles; read addr 255 afterwards -> 16'h0000.
REQ-034 Assert rst for 3 ns in mid-cycle during a read, before the next edge -> rvalid, rdata and ready go 0 without a clk edge; INIT restarts and completes in 256 cycles.
REQ-035 Random write/read sequences against a byte-masked reference model, including clr pulses during INIT -> zero mismatches.
